// File: rtl/fp_stream_accumulator_pkg.sv
// Shared types and constants for the streaming double-precision accumulator.
package fp_acc_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 16;

    localparam logic [63:0] FP_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FP_ONE  = 64'h3FF0_0000_0000_0000;

    // DRAIN is only reachable when FP_ACC_TIMEOUT_EN is defined.
    typedef enum logic [2:0] {
        RESET = 3'd0,
        IDLE  = 3'd1,
        ACCUM = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5,
        DRAIN = 3'd6
    } state_t;

endpackage

// File: rtl/fp_stream_accumulator_if.sv
// Request/response link between the accumulator and the external FP adder.
interface fp_stream_accumulator_if #(parameter int DATA_W = 64);

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic              add_start;
    logic [DATA_W-1:0] add_result;
    logic              add_done;

    // Accumulator side: issues operands, receives the sum.
    modport master (
        output add_a, add_b, add_start,
        input  add_result, add_done
    );

    // Adder side.
    modport slave (
        input  add_a, add_b, add_start,
        output add_result, add_done
    );

endinterface

// File: rtl/fp_stream_accumulator.sv
// Streaming accumulator: sums one packet of doubles via an external adder
// (acc + x per element) and presents sum and element count downstream.
// Optional build macro FP_ACC_TIMEOUT_EN adds a WAIT watchdog, a sticky err
// flag and a DRAIN state that discards the rest of an aborted packet.
module fp_stream_accumulator
    import fp_acc_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    fp_stream_accumulator_if.master  add_if,
    output logic [DATA_W-1:0]        sum_data,
    output logic [CNT_W-1:0]         sum_count,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic                     err
);

    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   acc_q,       acc_d;
    logic [DATA_W-1:0]   elem_q,      elem_d;
    logic                last_q,      last_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [DATA_W-1:0]   add_a_q,     add_a_d;
    logic [DATA_W-1:0]   add_b_q,     add_b_d;
    logic                add_start_q, add_start_d;
    logic                in_ready_q,  in_ready_d;
    logic [DATA_W-1:0]   sum_data_q,  sum_data_d;
    logic [CNT_W-1:0]    sum_count_q, sum_count_d;
    logic                sum_valid_q, sum_valid_d;
    logic                accept_s;

`ifdef FP_ACC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]     wait_cnt_q,  wait_cnt_d;
    logic                err_q,       err_d;
`endif

    // in_ready_q mirrors "state_q is IDLE/ACCUM/DRAIN", so it doubles as the accept qualifier.
    assign accept_s = in_valid & in_ready_q;

    // Next-state, datapath updates and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        elem_d      = elem_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        sum_data_d  = sum_data_q;
        sum_count_d = sum_count_q;
`ifdef FP_ACC_TIMEOUT_EN
        wait_cnt_d  = '0;
        err_d       = err_q;
`endif
        case (state_q)
            RESET: begin
                state_d = IDLE;
            end
            IDLE: begin
                // First element seeds the accumulator directly, no add issued.
                if (accept_s) begin
                    acc_d   = in_data;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = in_last ? DONE : ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    elem_d  = in_data;
                    last_d  = in_last;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    add_a_d = acc_q;
                    add_b_d = in_data;
                    state_d = START;
                end else begin
                    state_d = ACCUM;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (add_if.add_done) begin
                    acc_d   = add_if.add_result;
                    state_d = last_q ? DONE : ACCUM;
                end else begin
`ifdef FP_ACC_TIMEOUT_EN
                    if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        // Aborted element already carried in_last: nothing left to drain.
                        state_d = last_q ? IDLE : DRAIN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = WAIT;
`endif
                end
            end
            DONE: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
`ifdef FP_ACC_TIMEOUT_EN
                if (accept_s && in_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = RESET;
            end
        endcase

        in_ready_d  = (state_d == IDLE) || (state_d == ACCUM) || (state_d == DRAIN);
        add_start_d = (state_d == START);
        sum_valid_d = (state_d == DONE);
        // Capture the result once on entry to DONE so it stays stable while waiting.
        if ((state_d == DONE) && (state_q != DONE)) begin
            sum_data_d  = acc_d;
            sum_count_d = cnt_d;
        end else begin
            sum_data_d  = sum_data_q;
            sum_count_d = sum_count_q;
        end
    end

    // State and datapath registers; async reset discards any in-flight work.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET;
            acc_q       <= '0;
            elem_q      <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_start_q <= 1'b0;
            in_ready_q  <= 1'b0;
            sum_data_q  <= '0;
            sum_count_q <= '0;
            sum_valid_q <= 1'b0;
`ifdef FP_ACC_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            elem_q      <= elem_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_start_q <= add_start_d;
            in_ready_q  <= in_ready_d;
            sum_data_q  <= sum_data_d;
            sum_count_q <= sum_count_d;
            sum_valid_q <= sum_valid_d;
`ifdef FP_ACC_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready         = in_ready_q;
    assign add_if.add_a     = add_a_q;
    assign add_if.add_b     = add_b_q;
    assign add_if.add_start = add_start_q;
    assign sum_data         = sum_data_q;
    assign sum_count        = sum_count_q;
    assign sum_valid        = sum_valid_q;
`ifdef FP_ACC_TIMEOUT_EN
    assign err              = err_q;
`else
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator with a 5-cycle behavioural adder.
// The timeout scenario is compiled only when FP_ACC_TIMEOUT_EN is defined.
module tb_fp_stream_accumulator;
    import fp_acc_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] sum_data;
    logic [15:0] sum_count;
    logic        sum_valid;
    logic        sum_ready;
    logic        err;

    int tests = 0;
    int fails = 0;

    // Adder model and spurious-response injection
    logic        model_en   = 1'b1;
    logic        model_done = 1'b0;
    logic [63:0] model_res  = 64'h0;
    int          pend_cnt   = 0;
    logic        spur_done  = 1'b0;
    logic [63:0] spur_res   = 64'h4059_0000_0000_0000;
    int          start_cnt  = 0;
    int          svalid_cnt = 0;

    fp_stream_accumulator_if #(.DATA_W(64)) ifc ();

    assign ifc.add_done   = model_done | spur_done;
    assign ifc.add_result = spur_done ? spur_res : model_res;

    fp_stream_accumulator #(.DATA_W(64), .CNT_W(16), .TIMEOUT(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .add_if    (ifc),
        .sum_data  (sum_data),
        .sum_count (sum_count),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural adder: result appears 5 cycles after a start, one-cycle done.
    always @(negedge clock) begin
        if (ifc.add_start && model_en) begin
            pend_cnt   <= 5;
            model_res  <= $realtobits($bitstoreal(ifc.add_a) + $bitstoreal(ifc.add_b));
            model_done <= 1'b0;
        end else if (pend_cnt == 1) begin
            pend_cnt   <= 0;
            model_done <= 1'b1;
        end else begin
            if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
            model_done <= 1'b0;
        end
    end

    // Event counters for add_start cycles and sum_valid cycles.
    always @(negedge clock) begin
        if (ifc.add_start) start_cnt  <= start_cnt + 1;
        if (sum_valid)     svalid_cnt <= svalid_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [63:0] d, input logic l);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1; in_last = l;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clock);
        in_valid = 1'b0; in_last = 1'b0; in_data = 64'h0;
    endtask

    task automatic wait_sum();
        int n;
        n = 0;
        while (!sum_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("sum_valid_wait", {63'd0, sum_valid}, 64'd1);
    endtask

    task automatic accept_sum();
        sum_ready = 1'b1;
        @(negedge clock);
        sum_ready = 1'b0;
        chk("post_accept_valid", {63'd0, sum_valid}, 64'd0);
        chk("post_accept_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset_n = 1'b0; in_data = 64'h0; in_valid = 1'b0; in_last = 1'b0; sum_ready = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_add_start", {63'd0, ifc.add_start}, 64'd0);
        chk("rst_sum_valid", {63'd0, sum_valid}, 64'd0);
        chk("rst_err",       {63'd0, err}, 64'd0);
        chk("rst_sum_data",  sum_data, 64'h0);
        chk("rst_sum_count", {48'd0, sum_count}, 64'd0);
        chk("rst_add_a",     ifc.add_a, 64'h0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Test 1: 1.0 + 2.0 + 3.0 = 6.0
        base = start_cnt;
        send(FP_ONE, 1'b0);
        send(64'h4000_0000_0000_0000, 1'b0);
        chk("t1_start_ready", {63'd0, in_ready}, 64'd0);
        chk("t1_start_pulse", {63'd0, ifc.add_start}, 64'd1);
        chk("t1_add_a", ifc.add_a, FP_ONE);
        chk("t1_add_b", ifc.add_b, 64'h4000_0000_0000_0000);
        send(64'h4008_0000_0000_0000, 1'b1);
        wait_sum();
        chk("t1_sum_data",  sum_data, 64'h4018_0000_0000_0000);
        chk("t1_sum_count", {48'd0, sum_count}, 64'd3);
        chk("t1_starts", 64'(start_cnt - base), 64'd2);
        accept_sum();

        // Test 2: single element, no add issued
        base = start_cnt;
        send(64'h3FF3_AE14_7AE1_47AE, 1'b1);
        chk("t2_valid_next", {63'd0, sum_valid}, 64'd1);
        chk("t2_sum_data",  sum_data, 64'h3FF3_AE14_7AE1_47AE);
        chk("t2_sum_count", {48'd0, sum_count}, 64'd1);
        chk("t2_starts", 64'(start_cnt - base), 64'd0);
        accept_sum();

        // Test 3: downstream stall for 10 cycles
        send(FP_ONE, 1'b0);
        send(64'h4000_0000_0000_0000, 1'b1);
        wait_sum();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t3_hold_data",  sum_data, 64'h4008_0000_0000_0000);
            chk("t3_hold_count", {48'd0, sum_count}, 64'd2);
            chk("t3_hold_ready", {63'd0, in_ready}, 64'd0);
            chk("t3_hold_valid", {63'd0, sum_valid}, 64'd1);
        end
        accept_sum();

        // Test 4: reset during WAIT, late adder result must be ignored
        base = svalid_cnt;
        send(FP_ONE, 1'b0);
        send(64'h4000_0000_0000_0000, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_add_a",   ifc.add_a, 64'h0);
        chk("t4_rst_add_b",   ifc.add_b, 64'h0);
        chk("t4_rst_ready",   {63'd0, in_ready}, 64'd0);
        chk("t4_rst_start",   {63'd0, ifc.add_start}, 64'd0);
        chk("t4_rst_count",   {48'd0, sum_count}, 64'd0);
        chk("t4_rst_data",    sum_data, 64'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        chk("t4_no_sum", 64'(svalid_cnt - base), 64'd0);
        chk("t4_idle_ready", {63'd0, in_ready}, 64'd1);
        send(64'h4000_0000_0000_0000, 1'b0);
        send(64'h4000_0000_0000_0000, 1'b1);
        wait_sum();
        chk("t4_sum_data",  sum_data, 64'h4010_0000_0000_0000);
        chk("t4_sum_count", {48'd0, sum_count}, 64'd2);
        accept_sum();

        // Test 6: spurious add_done in IDLE and ACCUM
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        send(FP_ONE, 1'b0);
        spur_done = 1'b1;
        @(negedge clock);
        spur_done = 1'b0;
        chk("t6_accum_ready", {63'd0, in_ready}, 64'd1);
        send(FP_ONE, 1'b1);
        wait_sum();
        chk("t6_sum_data",  sum_data, 64'h4000_0000_0000_0000);
        chk("t6_sum_count", {48'd0, sum_count}, 64'd2);
        accept_sum();

`ifdef FP_ACC_TIMEOUT_EN
        // Test 5: adder never answers, watchdog aborts and drains
        model_en = 1'b0;
        base = svalid_cnt;
        send(FP_ONE, 1'b0);
        send(64'h4000_0000_0000_0000, 1'b0);
        repeat (16) @(negedge clock);
        chk("t5_err_early", {63'd0, err}, 64'd0);
        @(negedge clock);
        chk("t5_err_set",   {63'd0, err}, 64'd1);
        chk("t5_drain_ready", {63'd0, in_ready}, 64'd1);
        send(64'h4008_0000_0000_0000, 1'b0);
        chk("t5_drain_cont", {63'd0, in_ready}, 64'd1);
        send(64'h4010_0000_0000_0000, 1'b1);
        repeat (3) @(negedge clock);
        chk("t5_no_sum",    64'(svalid_cnt - base), 64'd0);
        chk("t5_err_sticky", {63'd0, err}, 64'd1);
        chk("t5_idle_ready", {63'd0, in_ready}, 64'd1);
        model_en = 1'b1;
`else
        chk("err_tied_low", {63'd0, err}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
